spectrum_peak_search: RTL and testbench

- Sits directly downstream of the FFT magnitude stage and consumes its magnitude/address/valid stream (8192 bins, 13-bit address).
- Per frame, finds the largest magnitude inside a configurable bin window.
- Also captures the magnitudes of the two adjacent bins, for later frequency interpolation.
- Publishes one result per complete, address-consistent frame to the measurement/display logic.

---
 rtl/spectrum_peak_search.sv | 172 +++++++++++++++++
 tb/tb_spectrum_peak_search.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_search.sv
// Per-frame peak search over a bin window of the FFT magnitude stream.
// Tracks the largest in-window magnitude, its bin and both neighbour
// magnitudes, and publishes one result per complete, in-order frame.
module spectrum_peak_search #(
  parameter int ADDR_W    = 13,
  parameter int MAG_W     = 16,
  parameter int FRAME_LEN = 8192,
  parameter int BIN_LO    = 1,
  parameter int BIN_HI    = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MAG_W-1:0]  mag_in,
  input  logic [ADDR_W-1:0] mag_addr_in,
  input  logic              mag_valid_in,
  input  logic              enable,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_left,
  output logic [MAG_W-1:0]  peak_right,
  output logic              result_valid,
  output logic [15:0]       frame_cnt,
  output logic              sync_err
);

  localparam logic [ADDR_W-1:0] L_BIN_LO = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] L_BIN_HI = ADDR_W'(BIN_HI);
  localparam logic [ADDR_W-1:0] L_LAST   = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic {SEEK, RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_exp_addr, w_exp_nxt;
  logic [MAG_W-1:0]  r_max, w_max_nxt;
  logic [ADDR_W-1:0] r_bin, w_bin_nxt;
  logic [MAG_W-1:0]  r_prev, w_prev_nxt;
  logic [MAG_W-1:0]  r_left, w_left_nxt;
  logic [MAG_W-1:0]  r_right, w_right_nxt;
  logic              r_pend, w_pend_nxt;

  logic [MAG_W-1:0]  r_peak_mag, r_peak_left, r_peak_right;
  logic [ADDR_W-1:0] r_peak_bin;
  logic              r_result_valid, r_sync_err;
  logic [15:0]       r_frame_cnt;

  logic w_in_order, w_disc, w_start, w_take, w_last, w_in_win;

  // Classify the incoming sample against the frame tracking state.
  always_comb begin
    w_in_order = (r_state == RUN) && mag_valid_in && (mag_addr_in == r_exp_addr);
    w_disc     = (r_state == RUN) && mag_valid_in && (mag_addr_in != r_exp_addr);
    // A frame starts from SEEK, or straight out of a discontinuity whose
    // offending sample is itself a valid bin-0 start.
    w_start    = mag_valid_in && enable && (mag_addr_in == '0) &&
                 ((r_state == SEEK) || w_disc);
    w_take     = w_in_order || w_start;
    w_last     = w_take && (mag_addr_in == L_LAST);
    w_in_win   = (mag_addr_in >= L_BIN_LO) && (mag_addr_in <= L_BIN_HI);
  end

  // Next values of the running search: frame-start clear, right-neighbour
  // completion, then new-max capture (which may re-arm on the same sample).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    w_exp_nxt   = r_exp_addr;
    w_max_nxt   = r_max;
    w_bin_nxt   = r_bin;
    w_prev_nxt  = r_prev;
    w_left_nxt  = r_left;
    w_right_nxt = r_right;
    w_pend_nxt  = r_pend;
    if (w_start) begin
      w_max_nxt   = '0;
      w_bin_nxt   = L_BIN_LO;
      w_prev_nxt  = '0;
      w_left_nxt  = '0;
      w_right_nxt = '0;
      w_pend_nxt  = 1'b0;
    end
    if (w_take) begin
      if (w_pend_nxt) begin
        w_right_nxt = mag_in;
        w_pend_nxt  = 1'b0;
      end
      // Strictly greater: ties keep the lowest bin.
      if (w_in_win && (mag_in > w_max_nxt)) begin
        w_max_nxt   = mag_in;
        w_bin_nxt   = mag_addr_in;
        w_left_nxt  = w_prev_nxt;
        w_right_nxt = '0;
        w_pend_nxt  = 1'b1;
      end
      w_prev_nxt = mag_in;
      w_exp_nxt  = mag_addr_in + ADDR_W'(1);
    end
  end

  // Next-state logic for frame tracking.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEEK: if (w_start) w_state_nxt = RUN;
      RUN: begin
        if (w_last)                 w_state_nxt = SEEK;
        else if (w_disc && !w_start) w_state_nxt = SEEK;
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) r_state <= SEEK;
    else        r_state <= w_state_nxt;
  end

  // Running search registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_addr <= '0;
      r_max      <= '0;
      r_bin      <= '0;
      r_prev     <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_exp_addr <= w_exp_nxt;
      r_max      <= w_max_nxt;
      r_bin      <= w_bin_nxt;
      r_prev     <= w_prev_nxt;
      r_left     <= w_left_nxt;
      r_right    <= w_right_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

  // Result publication, one cycle after the last bin, and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_mag     <= '0;
      r_peak_bin     <= '0;
      r_peak_left    <= '0;
      r_peak_right   <= '0;
      r_result_valid <= 1'b0;
      r_frame_cnt    <= '0;
      r_sync_err     <= 1'b0;
    end else begin
      r_result_valid <= w_last;
      r_sync_err     <= w_disc;
      if (w_last) begin
        r_peak_mag   <= w_max_nxt;
        r_peak_bin   <= w_bin_nxt;
        r_peak_left  <= w_left_nxt;
        r_peak_right <= w_right_nxt;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign peak_mag     = r_peak_mag;
  assign peak_bin     = r_peak_bin;
  assign peak_left    = r_peak_left;
  assign peak_right   = r_peak_right;
  assign result_valid = r_result_valid;
  assign frame_cnt    = r_frame_cnt;
  assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_spectrum_peak_search.sv
// Directed bench for spectrum_peak_search: a frame-level model computes the
// expected peak from the captured bins, checked every cycle, plus literal
// expectations for each scenario.
module tb_spectrum_peak_search;

  localparam int ADDR_W    = 13;
  localparam int MAG_W     = 16;
  localparam int FRAME_LEN = 8192;
  localparam int BIN_LO    = 1;
  localparam int BIN_HI    = 4095;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [MAG_W-1:0]  mag_in = '0;
  logic [ADDR_W-1:0] mag_addr_in = '0;
  logic              mag_valid_in = 1'b0;
  logic              enable = 1'b1;
  logic [MAG_W-1:0]  peak_mag, peak_left, peak_right;
  logic [ADDR_W-1:0] peak_bin;
  logic              result_valid, sync_err;
  logic [15:0]       frame_cnt;

  spectrum_peak_search #(
    .ADDR_W(ADDR_W), .MAG_W(MAG_W), .FRAME_LEN(FRAME_LEN),
    .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_addr_in(mag_addr_in),
    .mag_valid_in(mag_valid_in), .enable(enable), .peak_mag(peak_mag),
    .peak_bin(peak_bin), .peak_left(peak_left), .peak_right(peak_right),
    .result_valid(result_valid), .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [MAG_W-1:0] fr  [FRAME_LEN];  // stimulus frame
  logic [MAG_W-1:0] cap [FRAME_LEN];  // model's view of the frame in flight

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  int               m_next;          // next expected bin, -1 when not in a frame
  logic             p_rv, p_sync;    // expectations for the cycle after an edge
  logic [MAG_W-1:0] p_mag, p_left, p_right;
  int               p_bin;
  logic [MAG_W-1:0] e_mag, e_left, e_right;
  int               e_bin;
  logic [15:0]      e_cnt;

  initial begin
    m_next = -1; p_rv = 0; p_sync = 0;
    p_mag = 0; p_left = 0; p_right = 0; p_bin = 0;
    e_mag = 0; e_left = 0; e_right = 0; e_bin = 0; e_cnt = 0;
    forever begin
      @(posedge clk);
      p_rv = 0;
      p_sync = 0;
      if (!rst_n) begin
        m_next = -1;
      end else if (mag_valid_in) begin
        int a;
        a = int'(mag_addr_in);
        if (m_next >= 0 && a != m_next) begin
          p_sync = 1;
          m_next = -1;
        end
        if (m_next < 0 && a == 0 && enable) m_next = 0;
        if (m_next >= 0) begin
          cap[a] = mag_in;
          if (a == FRAME_LEN - 1) begin
            // Whole frame captured: find the first strict maximum in the window.
            logic found;
            found = 0; p_mag = 0; p_bin = BIN_LO; p_left = 0; p_right = 0;
            for (int k = BIN_LO; k <= BIN_HI; k++)
              if (cap[k] > p_mag) begin
                p_mag = cap[k]; p_bin = k; found = 1;
              end
            if (found) begin
              p_left  = (p_bin > 0) ? cap[p_bin-1] : '0;
              p_right = (p_bin < FRAME_LEN - 1) ? cap[p_bin+1] : '0;
            end
            p_rv = 1;
            m_next = -1;
          end else begin
            m_next = a + 1;
          end
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        e_mag = 0; e_left = 0; e_right = 0; e_bin = 0; e_cnt = 0;
        p_rv = 0; p_sync = 0;
      end else if (p_rv) begin
        e_mag = p_mag; e_bin = p_bin; e_left = p_left; e_right = p_right;
        e_cnt = e_cnt + 16'd1;
      end
      check("result_valid", {31'd0, result_valid}, {31'd0, p_rv});
      check("sync_err", {31'd0, sync_err}, {31'd0, p_sync});
      check("peak_mag", {16'd0, peak_mag}, {16'd0, e_mag});
      check("peak_bin", {19'd0, peak_bin}, e_bin);
      check("peak_left", {16'd0, peak_left}, {16'd0, e_left});
      check("peak_right", {16'd0, peak_right}, {16'd0, e_right});
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, e_cnt});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input int a, input logic [MAG_W-1:0] m);
    @(posedge clk);
    #1;
    mag_valid_in = v;
    mag_addr_in  = ADDR_W'(a);
    mag_in       = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(0, FRAME_LEN - 1)), MAG_W'($urandom));
  endtask

  // Sends bins lo..hi in order; gap_pct gives the chance of an idle cycle
  // before each bin except the first.
  task automatic send(input int lo, input int hi, input int gap_pct);
    for (int a = lo; a <= hi; a++) begin
      if (a != lo && gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      drive(1'b1, a, fr[a]);
    end
  endtask

  task automatic fill(input logic [MAG_W-1:0] v);
    for (int i = 0; i < FRAME_LEN; i++) fr[i] = v;
  endtask

  task automatic check_peak(input string tag, input int bin, input logic [MAG_W-1:0] m,
                            input logic [MAG_W-1:0] l, input logic [MAG_W-1:0] r,
                            input int cnt);
    check({tag, "_bin"}, {19'd0, peak_bin}, bin);
    check({tag, "_mag"}, {16'd0, peak_mag}, {16'd0, m});
    check({tag, "_left"}, {16'd0, peak_left}, {16'd0, l});
    check({tag, "_right"}, {16'd0, peak_right}, {16'd0, r});
    check({tag, "_cnt"}, {16'd0, frame_cnt}, cnt);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_peak("reset", 0, 16'h0, 16'h0, 16'h0, 0);
    check("reset_rv", {31'd0, result_valid}, 0);
    check("reset_sync", {31'd0, sync_err}, 0);
    #1 rst_n = 1'b1;
    idle(2);

    // Single tone.
    fill(16'h0010);
    fr[99] = 16'h2000; fr[100] = 16'h4000; fr[101] = 16'h1000;
    send(0, FRAME_LEN - 1, 0);
    check("t1_rv_before", {31'd0, result_valid}, 0);
    idle(1);
    check("t1_rv_pulse", {31'd0, result_valid}, 1);
    check_peak("t1", 100, 16'h4000, 16'h2000, 16'h1000, 1);
    idle(1);
    check("t1_rv_after", {31'd0, result_valid}, 0);

    // Ties and window limits.
    fill(16'h0000);
    fr[0] = 16'hFFFF; fr[5000] = 16'hFFFF; fr[200] = 16'h7FFF; fr[300] = 16'h7FFF;
    send(0, FRAME_LEN - 1, 0);
    idle(1);
    check_peak("t2", 200, 16'h7FFF, 16'h0, 16'h0, 2);

    // Address skip, then a clean frame.
    fill(16'h0003);
    fr[50] = 16'h0300;
    send(0, 10, 0);
    drive(1'b1, 12, fr[12]);
    idle(1);
    check("t3_sync_pulse", {31'd0, sync_err}, 1);
    check("t3_no_result", {31'd0, result_valid}, 0);
    idle(1);
    check("t3_sync_end", {31'd0, sync_err}, 0);
    check("t3_cnt_hold", {16'd0, frame_cnt}, 2);
    send(0, FRAME_LEN - 1, 0);
    idle(1);
    check_peak("t3", 50, 16'h0300, 16'h0003, 16'h0003, 3);

    // Back-to-back frames with random gaps; B's bin 0 lands in A's result cycle.
    fill(16'h0001);
    fr[7] = 16'h0800;
    send(0, FRAME_LEN - 1, 25);
    fill(16'h0005);
    fr[4095] = 16'h0900; fr[4096] = 16'h0123;
    send(0, FRAME_LEN - 1, 25);
    idle(1);
    check_peak("t4", 4095, 16'h0900, 16'h0005, 16'h0123, 5);

    // enable drops mid-frame: frame publishes, next frame is ignored.
    fill(16'h0002);
    fr[1234] = 16'h0AAA;
    send(0, 2999, 10);
    enable = 1'b0;
    send(3000, FRAME_LEN - 1, 10);
    idle(1);
    check_peak("t5", 1234, 16'h0AAA, 16'h0002, 16'h0002, 6);
    fill(16'h0F00);
    send(0, 20, 0);
    idle(3);
    check_peak("t5_ignored", 1234, 16'h0AAA, 16'h0002, 16'h0002, 6);
    enable = 1'b1;

    // Reset mid-frame.
    fill(16'h0007);
    fr[2000] = 16'h1111;
    send(0, 3999, 0);
    drive(1'b1, 4000, fr[4000]);
    #2;
    rst_n = 1'b0;
    mag_valid_in = 1'b0;
    #1;
    check_peak("t6_async", 0, 16'h0, 16'h0, 16'h0, 0);
    check("t6_async_rv", {31'd0, result_valid}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(4001, FRAME_LEN - 1, 0);
    idle(1);
    check("t6_no_result", {31'd0, result_valid}, 0);
    check("t6_cnt_zero", {16'd0, frame_cnt}, 0);
    send(0, FRAME_LEN - 1, 0);
    idle(1);
    check("t6_rv", {31'd0, result_valid}, 1);
    check_peak("t6", 2000, 16'h1111, 16'h0007, 16'h0007, 1);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
